// File: rtl/vproc_csr_bridge.sv
// vproc_csr_bridge: turns VProc level-held WE/RD requests into single-cycle
// CSR strobes and returns a one-cycle WRAck/RDAck once csr_ack comes back.
// Flow: IDLE -> ISSUE (strobe) -> [WAIT] -> ACK (VProc ack) -> IDLE.
// Optional build macro VPROC_CSR_TIMEOUT_EN: adds a WAIT-state timeout that
// completes the access with err set and ERR_DATA returned on reads.
module vproc_csr_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Addr,
  input  logic [3:0]  BE,
  input  logic        WE,
  input  logic        RD,
  input  logic [31:0] DataOut,
  input  logic        BurstLast,
  output logic [31:0] DataIn,
  output logic        WRAck,
  output logic        RDAck,
  output logic [31:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic [3:0]  csr_be,
  output logic        csr_last,
  output logic        csr_we,
  output logic        csr_re,
  input  logic [31:0] csr_rdata,
  input  logic        csr_ack,
  output logic        err,
  output logic [15:0] acc_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t state;
  logic   is_wr;   // current access is a write (WE wins when both are high)

`ifdef VPROC_CSR_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = ^{ERR_DATA, 16'(TIMEOUT_CYCLES)};
`endif

  // Bridge FSM; every output is a register so strobes and acks are glitch-free.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      is_wr     <= 1'b0;
      WRAck     <= 1'b0;
      RDAck     <= 1'b0;
      csr_we    <= 1'b0;
      csr_re    <= 1'b0;
      csr_addr  <= '0;
      csr_wdata <= '0;
      csr_be    <= '0;
      csr_last  <= 1'b0;
      DataIn    <= '0;
      err       <= 1'b0;
      acc_cnt   <= '0;
`ifdef VPROC_CSR_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      // strobes and acks are single-cycle pulses by default
      WRAck  <= 1'b0;
      RDAck  <= 1'b0;
      csr_we <= 1'b0;
      csr_re <= 1'b0;
      case (state)
        IDLE: begin
          if (WE || RD) begin
            csr_addr  <= Addr;
            csr_wdata <= DataOut;
            csr_be    <= BE;
            csr_last  <= BurstLast;
            is_wr     <= WE;
            csr_we    <= WE;
            csr_re    <= ~WE;
            if (WE && RD) err <= 1'b1;
`ifdef VPROC_CSR_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
            state     <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (csr_ack) begin
            WRAck <= is_wr;
            RDAck <= ~is_wr;
            if (!is_wr) DataIn <= csr_rdata;
            state <= ACK;
          end else if (state == ISSUE) begin
            state <= WAIT;
`ifdef VPROC_CSR_TIMEOUT_EN
          end else if (tmo_cnt == TMO_LAST) begin
            // target never answered: complete with an error
            WRAck <= is_wr;
            RDAck <= ~is_wr;
            if (!is_wr) DataIn <= ERR_DATA;
            err   <= 1'b1;
            state <= ACK;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
`endif
          end
        end
        ACK: begin
          // request inputs deliberately ignored here so a held level is not re-issued
          acc_cnt <= acc_cnt + 16'd1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
